// File: rtl/alu_issue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_issue_pkg                                              |
// | Description : Shared opcodes, FSM state encoding and command struct for  |
// |               the ALU issue stage.                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package alu_issue_pkg;

  // Operand width of the downstream ALU; the issue stage DW must equal this.
  localparam int ALU_DW = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_INV = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic [2:0]        op;
  } cmd_t;

  // Opcodes whose result is undefined when operand b is zero.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ALU_4                                                      |
// | Description : 4-bit combinational ALU driven by the issue stage. Divide  |
// |               and modulo by zero return all ones (the stage masks it).   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ALU_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] x,
  output logic [3:0] y
);
  import alu_issue_pkg::*;

  logic [7:0] prod;
  assign prod = a * b;

  // Pure combinational opcode decode; overflow is truncated to 4 bits.
  always_comb begin
    y = 4'h0;
    case (x)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_MUL: y = prod[3:0];
      OP_DIV: y = (b == 4'h0) ? 4'hF : a / b;
      OP_MOD: y = (b == 4'h0) ? 4'hF : a % b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_INV: y = ~a;
      default: y = 4'h0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/alu_issue_stage_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_cmd_fifo                                               |
// | Description : Show-ahead command FIFO with count/full/empty. A write and |
// |               a read in the same cycle are both honoured when full.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_issue_stage                                            |
// | Description : Buffers ALU commands, drives the ALU from registers and    |
// |               returns each result with its opcode and a div-by-zero flag.|
// |               Optional macro ALU_ISSUE_STATS_EN adds saturating          |
// |               issue/error counters.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [2:0]    cmd_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_x,
  input  logic [DW-1:0] alu_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [2:0]    res_op,
  output logic          res_err
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [7:0]    stat_issued,
  output logic [7:0]    stat_err
`endif
);
  state_t                 state;
  cmd_t                   push_word;
  cmd_t                   head_word;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push;
  logic                   pop;
  logic                   div_zero;

  assign push_word.a  = cmd_a;
  assign push_word.b  = cmd_b;
  assign push_word.op = cmd_op;

  // cmd_ready comes straight from the registered FIFO count.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  // Next command is issued from IDLE, or in OUT on the same edge the result leaves.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) ||
                (state == ST_OUT && res_valid && res_ready));

  assign div_zero = is_div_op(alu_x) && (alu_b == '0);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Issue/capture FSM together with the ALU operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_x     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            alu_a <= head_word.a;
            alu_b <= head_word.b;
            alu_x <= head_word.op;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU output is undefined for a zero divisor, so it is replaced.
          res_data  <= div_zero ? '0 : alu_y;
          res_op    <= alu_x;
          res_err   <= div_zero;
          res_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_a <= head_word.a;
              alu_b <= head_word.b;
              alu_x <= head_word.op;
              state <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Saturating counters: one issue per EXEC cycle, errors when div-by-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= 8'h00;
      stat_err    <= 8'h00;
    end else if (state == ST_EXEC) begin
      if (stat_issued != 8'hFF) stat_issued <= stat_issued + 8'h01;
      if (div_zero && stat_err != 8'hFF) stat_err <= stat_err + 8'h01;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_issue_stage                                         |
// | Description : Scoreboard bench for alu_issue_stage closed over ALU_4.    |
// |               Define ALU_ISSUE_STATS_EN to also check the counters.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_issue_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'h0;
  logic [3:0] cmd_b = 4'h0;
  logic [2:0] cmd_op = 3'h0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_x;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [2:0] res_op;
  logic       res_err;
`ifdef ALU_ISSUE_STATS_EN
  logic [7:0] stat_issued, stat_err;
`endif

  typedef struct {
    logic [3:0] data;
    logic [2:0] op;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_xfer = -1;
  bit   gap_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_issue_stage #(.DEPTH(4), .DW(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_err(res_err)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_err(stat_err)
`endif
  );

  ALU_4 u_alu (.a(alu_a), .b(alu_b), .x(alu_x), .y(alu_y));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of ALU + stage, written from the opcode table.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    logic [7:0] p;
    p = a * b;
    e.op = op;
    e.err = 1'b0;
    case (op)
      3'd0: e.data = a + b;
      3'd1: e.data = a - b;
      3'd2: e.data = p[3:0];
      3'd3: e.data = (b == 0) ? 4'h0 : a / b;
      3'd4: e.data = (b == 0) ? 4'h0 : a % b;
      3'd5: e.data = a & b;
      3'd6: e.data = a | b;
      default: e.data = ~a;
    endcase
    if ((op == 3'd3 || op == 3'd4) && b == 0) e.err = 1'b1;
    return e;
  endfunction

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("push_timeout", 0, 1);
    else sb.push_back(model(a, b, op));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || res_valid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", (sb.size() == 0 && !res_valid), 1);
  endtask

  // Monitor: a transfer seen at a negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_op", res_op, e.op);
        check("res_err", res_err, e.err);
      end
      if (gap_on && last_xfer >= 0) check("result_gap", cyc - last_xfer, 2);
      last_xfer = cyc;
    end
  end

  initial begin
    int nd;
    logic [2:0] op;
    logic [3:0] b;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_alu_abx", {alu_a, alu_b, 1'b0, alu_x}, 0);
    check("rst_res_fields", {res_data, 1'b0, res_op, 3'b0, res_err}, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;

    // Single add with latency check.
    push_cmd(4'd3, 4'd4, 3'b000);
    @(posedge clk); #1;
    check("lat_n1_valid", res_valid, 0);
    @(posedge clk); #1;
    check("lat_n2_valid", res_valid, 1);
    wait_drain();

    // Divide and modulo by zero, then a legal divide.
    push_cmd(4'd9, 4'd0, 3'b011);
    push_cmd(4'd9, 4'd0, 3'b100);
    push_cmd(4'd9, 4'd2, 3'b011);
    wait_drain();

    // Backpressure: 5 accepted fill stage + FIFO; the 6th waits for release.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'(i + 1), 4'(i + 2), 3'(i));
    fork
      push_cmd(4'hE, 4'h3, 3'b110);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("full_cmd_ready", cmd_ready, 0);
        check("full_res_valid", res_valid, 1);
        res_ready = 1'b1;
      end
    join
    wait_drain();

    // Back-to-back mixed commands: one result every two cycles.
    last_xfer = -1;
    gap_on = 1'b1;
    push_cmd(4'd2, 4'd5, 3'b001);
    push_cmd(4'd5, 4'd5, 3'b010);
    push_cmd(4'hA, 4'h0, 3'b111);
    push_cmd(4'd7, 4'd9, 3'b000);
    push_cmd(4'hC, 4'h6, 3'b101);
    push_cmd(4'h1, 4'h8, 3'b110);
    push_cmd(4'hF, 4'h4, 3'b011);
    push_cmd(4'hF, 4'h4, 3'b100);
    wait_drain();
    gap_on = 1'b0;

    // Reset while a result is held and three commands are queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(4'(i), 4'(i + 1), 3'b000);
    nd = 0;
    while (!res_valid && nd < 20) begin
      @(posedge clk);
      nd++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_res_data", res_data, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("postrst_no_result", res_valid, 0);

    // Long run: 300 commands, exactly 10 with a zero divisor.
    for (int i = 0; i < 300; i++) begin
      if (i % 30 == 0) begin
        op = (i % 60 == 0) ? 3'b011 : 3'b100;
        b = 4'h0;
      end else begin
        op = 3'($urandom_range(0, 7));
        b = 4'($urandom_range(0, 15));
        if ((op == 3'b011 || op == 3'b100) && b == 0) b = 4'h1;
      end
      push_cmd(4'($urandom_range(0, 15)), b, op);
    end
    wait_drain();
`ifdef ALU_ISSUE_STATS_EN
    check("stat_issued_sat", stat_issued, 8'hFF);
    check("stat_err", stat_err, 8'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
